hv_ngram_bundle_core: RTL and testbench

//  Parametrised HDC encoder core. Holds an item memory of DIM_W-bit hypervector slices.

---
 rtl/hv_ngram_bundle_core_pkg.sv | 30 +++
 rtl/hv_ngram_bundle_core_item_mem.sv | 30 +++
 rtl/hv_ngram_bundle_core.sv | 198 +++++++++++++++++++
 tb/tb_hv_ngram_bundle_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_ngram_bundle_core_pkg.sv
// Shared types and helpers for the HDC n-gram bundling encoder slice.
// Width-derivation and majority helpers are written for the widest legal counter.
package hv_ngram_bundle_core_pkg;

  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic first;
    logic last_pos;
    logic last_seg;
  } sym_ctl_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Majority with tie-break: 1 when more than half of the n-grams set the bit.
  function automatic logic maj_bit(input logic [CNT_MAX_W-1:0] cnt,
                                   input logic [CNT_MAX_W-1:0] ngrams,
                                   input logic tie);
    logic [CNT_MAX_W:0] twice;
    logic [CNT_MAX_W:0] n;
    twice = {cnt, 1'b0};
    n     = {1'b0, ngrams};
    if (twice > n) return 1'b1;
    if (twice == n) return tie;
    return 1'b0;
  endfunction

endpackage

// File: rtl/hv_ngram_bundle_core_item_mem.sv
// Item memory: one write port plus a registered read port, mapped to block RAM.
// Writes win; no read is issued in a write cycle.
module hv_item_mem #(
  parameter int DIM_W  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DIM_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DIM_W-1:0]  rdata
);

  (* ram_style = "block" *) logic [DIM_W-1:0] mem_q [DEPTH];
  logic [DIM_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hv_ngram_bundle_core.sv
// HDC encoder slice: binds n-grams of rotated item vectors by XOR and bundles them
// into a per-bit saturating majority vote, one hypervector per sample.
module hv_ngram_bundle_core
  import hv_ngram_bundle_core_pkg::*;
#(
  parameter int DIM_W  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = clog2_min1(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DIM_W-1:0]  mem_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_sym,
  input  logic              in_last_pos,
  input  logic              in_last_seg,
  input  logic [DIM_W-1:0]  tie_hv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIM_W-1:0]  out_hv,
  output logic [CNT_W-1:0]  out_ngrams,
  output logic              out_sat
);

  localparam int POS_W = clog2_min1(DIM_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [DIM_W-1:0] rotr(input logic [DIM_W-1:0] v,
                                            input logic [POS_W-1:0] sh);
    logic [2*DIM_W-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[DIM_W-1:0];
  endfunction

  // Returns {clipped, value}; clipped flags an increment lost to saturation.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (!inc) return {1'b0, v};
    if (v == CNT_MAX) return {1'b1, v};
    return {1'b0, v + CNT_W'(1)};
  endfunction

  logic             accept, last_pos_in;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             first_q, first_d;
  logic             seg_pending_q, seg_pending_d;
  logic             vld_p0_q, vld_p0_d;
  logic [POS_W-1:0] pos_p0_q, pos_p0_d;
  sym_ctl_t         ctl_p0_q, ctl_p0_d;
  logic [DIM_W-1:0] item_rdata;
  logic [DIM_W-1:0] bind_q, bind_d;
  logic             vld_p1_q, vld_p1_d;
  logic             last_pos_p1_q, last_pos_p1_d;
  logic             last_seg_p1_q, last_seg_p1_d;
  logic [CNT_W-1:0] cnt_q [DIM_W];
  logic [CNT_W-1:0] cnt_d [DIM_W];
  logic [CNT_W-1:0] cnt_upd [DIM_W];
  logic [CNT_W-1:0] ngrams_q, ngrams_d, ngrams_upd;
  logic             sat_q, sat_d, sat_upd;
  logic [CNT_W:0]   inc_r;
  logic             do_acc;
  logic             out_valid_q, out_valid_d;
  logic [DIM_W-1:0] out_hv_q, out_hv_d;
  logic [CNT_W-1:0] out_ngrams_q, out_ngrams_d;
  logic             out_sat_q, out_sat_d;

  assign in_ready    = ~rst & ~mem_we & ~seg_pending_q;
  assign accept      = in_valid & in_ready;
  assign last_pos_in = in_last_pos | in_last_seg;

  hv_item_mem #(
    .DIM_W (DIM_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_item_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_addr),
    .wdata(mem_wdata),
    .re   (accept),
    .raddr(in_sym),
    .rdata(item_rdata)
  );

  // S0: symbol acceptance, position tracking, sample ownership
  always_comb begin
    pos_d         = pos_q;
    first_d       = first_q;
    seg_pending_d = seg_pending_q;
    if (accept) begin
      first_d = last_pos_in;
      if (last_pos_in || pos_q == POS_W'(DIM_W - 1)) pos_d = '0;
      else pos_d = pos_q + POS_W'(1);
      if (in_last_seg) seg_pending_d = 1'b1;
    end
    if (out_valid_q && out_ready) seg_pending_d = 1'b0;
    vld_p0_d          = accept;
    pos_p0_d          = pos_q;
    ctl_p0_d.first    = first_q;
    ctl_p0_d.last_pos = last_pos_in;
    ctl_p0_d.last_seg = in_last_seg;
  end

  // S1: bind the rotated item vector into the running n-gram
  always_comb begin
    vld_p1_d      = vld_p0_q;
    last_pos_p1_d = ctl_p0_q.last_pos;
    last_seg_p1_d = ctl_p0_q.last_seg;
    bind_d        = bind_q;
    if (vld_p0_q) bind_d = (ctl_p0_q.first ? '0 : bind_q) ^ rotr(item_rdata, pos_p0_q);
  end

  // S2: accumulate finished n-grams, threshold on the last one of the sample
  always_comb begin
    do_acc  = vld_p1_q & last_pos_p1_q;
    sat_upd = sat_q;
    inc_r   = '0;
    for (int i = 0; i < DIM_W; i++) begin
      inc_r      = sat_inc(cnt_q[i], do_acc & bind_q[i]);
      cnt_upd[i] = inc_r[CNT_W-1:0];
      sat_upd    = sat_upd | inc_r[CNT_W];
    end
    inc_r      = sat_inc(ngrams_q, do_acc);
    ngrams_upd = inc_r[CNT_W-1:0];
    sat_upd    = sat_upd | inc_r[CNT_W];

    out_valid_d  = out_valid_q & ~out_ready;
    out_hv_d     = out_hv_q;
    out_ngrams_d = out_ngrams_q;
    out_sat_d    = out_sat_q;
    cnt_d        = cnt_upd;
    ngrams_d     = ngrams_upd;
    sat_d        = sat_upd;
    if (vld_p1_q && last_seg_p1_q) begin
      for (int i = 0; i < DIM_W; i++) begin
        out_hv_d[i] = maj_bit(CNT_MAX_W'(cnt_upd[i]), CNT_MAX_W'(ngrams_upd), tie_hv[i]);
        cnt_d[i]    = '0;
      end
      out_valid_d  = 1'b1;
      out_ngrams_d = ngrams_upd;
      out_sat_d    = sat_upd;
      ngrams_d     = '0;
      sat_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q         <= '0;
      first_q       <= 1'b1;
      seg_pending_q <= 1'b0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      bind_q        <= '0;
      for (int i = 0; i < DIM_W; i++) cnt_q[i] <= '0;
      ngrams_q      <= '0;
      sat_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_hv_q      <= '0;
      out_ngrams_q  <= '0;
      out_sat_q     <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      first_q       <= first_d;
      seg_pending_q <= seg_pending_d;
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      bind_q        <= bind_d;
      cnt_q         <= cnt_d;
      ngrams_q      <= ngrams_d;
      sat_q         <= sat_d;
      out_valid_q   <= out_valid_d;
      out_hv_q      <= out_hv_d;
      out_ngrams_q  <= out_ngrams_d;
      out_sat_q     <= out_sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pos_p0_q <= pos_p0_d;
      ctl_p0_q <= ctl_p0_d;
    end
    if (vld_p0_q) begin
      last_pos_p1_q <= last_pos_p1_d;
      last_seg_p1_q <= last_seg_p1_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hv     = out_hv_q;
  assign out_ngrams = out_ngrams_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_hv_ngram_bundle_core.sv
// Scoreboard bench for hv_ngram_bundle_core: one CNT_W=8 slice and one CNT_W=2 slice
// share the memory-write and symbol buses; sel2 steers symbols to the narrow slice.
module tb_hv_ngram_bundle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_valid;
  logic [9:0]  in_sym;
  logic        in_last_pos, in_last_seg;
  logic [31:0] tie_hv;
  logic        out_ready;
  logic        sel2;

  logic        in_valid_a, in_ready_a, out_valid_a, out_sat_a;
  logic [31:0] out_hv_a;
  logic [7:0]  out_ngrams_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_sat_b;
  logic [31:0] out_hv_b;
  logic [1:0]  out_ngrams_b;

  assign in_valid_a = in_valid & ~sel2;
  assign in_valid_b = in_valid & sel2;

  always #5 clk = ~clk;

  hv_ngram_bundle_core #(.DIM_W(32), .DEPTH(1024), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sym(in_sym),
    .in_last_pos(in_last_pos), .in_last_seg(in_last_seg), .tie_hv(tie_hv),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_hv(out_hv_a),
    .out_ngrams(out_ngrams_a), .out_sat(out_sat_a)
  );

  hv_ngram_bundle_core #(.DIM_W(32), .DEPTH(1024), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sym(in_sym),
    .in_last_pos(in_last_pos), .in_last_seg(in_last_seg), .tie_hv(tie_hv),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_hv(out_hv_b),
    .out_ngrams(out_ngrams_b), .out_sat(out_sat_b)
  );

  typedef struct {
    logic [31:0] hv;
    int          ngrams;
    logic        sat;
    int          acc_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   prev_a  = 0;
  bit   prev_b  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endfunction

  // Monitor for the CNT_W=8 slice
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_a = 0;
    else begin
      if (out_valid_a && !prev_a) begin
        if (q_a.size() == 0) chk("a_unexpected_out_valid", 1, 0);
        else chk("a_latency", 64'(cyc), 64'(q_a[0].acc_cyc + 3));
      end
      if (out_valid_a && out_ready && q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_out_hv", 64'(out_hv_a), 64'(e.hv));
        chk("a_out_ngrams", 64'(out_ngrams_a), 64'(e.ngrams));
        chk("a_out_sat", 64'(out_sat_a), 64'(e.sat));
      end
      prev_a = out_valid_a && !out_ready;
    end
  end

  // Monitor for the CNT_W=2 slice
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_b = 0;
    else begin
      if (out_valid_b && !prev_b) begin
        if (q_b.size() == 0) chk("b_unexpected_out_valid", 1, 0);
        else chk("b_latency", 64'(cyc), 64'(q_b[0].acc_cyc + 3));
      end
      if (out_valid_b && out_ready && q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_out_hv", 64'(out_hv_b), 64'(e.hv));
        chk("b_out_ngrams", 64'(out_ngrams_b), 64'(e.ngrams));
        chk("b_out_sat", 64'(out_sat_b), 64'(e.sat));
      end
      prev_b = out_valid_b && !out_ready;
    end
  end

  function automatic logic cur_ready();
    return sel2 ? in_ready_b : in_ready_a;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input int addr, input logic [31:0] data);
    mem_we = 1'b1; mem_addr = 10'(addr); mem_wdata = data;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int sym, input bit lp, input bit ls, output int acc);
    bit ok = 0;
    acc = -1;
    in_valid = 1'b1; in_sym = 10'(sym); in_last_pos = lp; in_last_seg = ls;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cur_ready()) begin acc = cyc; ok = 1; end
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0; in_last_pos = 1'b0; in_last_seg = 1'b0;
    if (!ok) bound_fail("send_in_ready");
  endtask

  task automatic push(input logic [31:0] hv, input int ng, input logic sat, input int acc);
    exp_t e;
    e.hv = hv; e.ngrams = ng; e.sat = sat; e.acc_cyc = acc;
    if (sel2) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q_a.size() == 0 && q_b.size() == 0 && !out_valid_a && !out_valid_b) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) bound_fail("drain");
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ok;
    rst = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0; in_valid = 0; in_sym = 0;
    in_last_pos = 0; in_last_seg = 0; tie_hv = 0; out_ready = 1; sel2 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_a), 0);
    chk("rst_out_valid", 64'(out_valid_a), 0);
    chk("rst_out_hv", 64'(out_hv_a), 0);
    chk("rst_out_ngrams", 64'(out_ngrams_a), 0);
    chk("rst_out_sat", 64'(out_sat_a), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready_a), 1);
    @(posedge clk); #1;

    // Test 1: two-symbol n-gram, second item rotated by one
    wr(1, 32'h1); wr(2, 32'h3);
    send(1, 0, 0, acc);
    idle(2);
    send(2, 1, 1, acc); push(32'h8000_0000, 1, 0, acc);
    drain();

    // Test 2: tie resolved by tie_hv
    wr(1, 32'h0F); wr(2, 32'hF0); tie_hv = 32'h0000_00FF;
    send(1, 1, 0, acc);
    send(2, 1, 1, acc); push(32'h0000_00FF, 2, 0, acc);
    drain();

    // Test 3: majority of three; last_seg alone closes the final n-gram
    send(1, 1, 0, acc);
    send(1, 1, 0, acc);
    send(2, 0, 1, acc); push(32'h0000_000F, 3, 0, acc);
    drain();

    // Test 4: backpressure holds the result and blocks input
    out_ready = 0;
    send(1, 1, 1, acc); push(32'h0000_000F, 1, 0, acc);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid_a) begin ok = 1; break; end
    end
    if (!ok) bound_fail("bp_out_valid");
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", 64'(in_ready_a), 0);
      chk("bp_out_valid", 64'(out_valid_a), 1);
      chk("bp_out_hv", 64'(out_hv_a), 64'h0F);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready_a), 1);
    chk("bp_release_out_valid", 64'(out_valid_a), 0);
    @(posedge clk); #1;
    send(2, 1, 1, acc); push(32'h0000_00F0, 1, 0, acc);
    drain();

    // Test 5: 33-symbol n-gram wraps the position counter
    wr(1, 32'h1); tie_hv = 32'h0;
    for (int k = 0; k < 32; k++) begin
      send(1, 0, 0, acc);
      if (k == 10) idle(1);
    end
    send(1, 1, 1, acc); push(32'hFFFF_FFFE, 1, 0, acc);
    drain();

    // Test 6: CNT_W=2 saturation, then reset mid-sample
    sel2 = 1;
    wr(1, 32'h1); wr(2, 32'h3);
    for (int k = 0; k < 3; k++) send(1, 1, 0, acc);
    send(1, 1, 1, acc); push(32'h0000_0001, 3, 1, acc);
    drain();
    send(2, 0, 0, acc);
    send(1, 1, 0, acc);
    send(2, 0, 0, acc);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready_b), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    idle(1);
    send(1, 0, 0, acc);
    send(2, 1, 1, acc); push(32'h8000_0000, 1, 0, acc);
    drain();

    chk("queue_a_empty", 64'(q_a.size()), 0);
    chk("queue_b_empty", 64'(q_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
